// File: rtl/pc_fetch_seq_if.sv
// Fetch-sequencer bus: control inputs from the decoder and PC/interrupt status back to it.
// The slave side is the sequencer; the master side is the decoder/core.
interface pc_fetch_seq_if #(
  parameter int ADDR_W = 10
);
  logic              STALL;
  logic              PC_LD;
  logic [1:0]        PC_MUX_SEL;
  logic [ADDR_W-1:0] FROM_IMMED;
  logic [ADDR_W-1:0] FROM_STACK;
  logic              INT_REQ;
  logic              INT_EN;
  logic [ADDR_W-1:0] PC_COUNT;
  logic              EXEC_EN;
  logic              INT_ACK;
  logic [ADDR_W-1:0] SAVED_PC;
  logic              INT_PEND;

  modport slave (
    input  STALL, PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, INT_REQ, INT_EN,
    output PC_COUNT, EXEC_EN, INT_ACK, SAVED_PC, INT_PEND
  );

  modport master (
    output STALL, PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, INT_REQ, INT_EN,
    input  PC_COUNT, EXEC_EN, INT_ACK, SAVED_PC, INT_PEND
  );
endinterface

// File: rtl/pc_fetch_seq.sv
// Program counter and FETCH/EXEC/INTR sequencer in front of a registered-read program ROM.
// Every output is a flop or a decode of the state register only.
module pc_fetch_seq #(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 10'h000,
  parameter logic [ADDR_W-1:0] INT_VECTOR = 10'h3FF
) (
  input  logic          CLK,
  input  logic          RST,
  pc_fetch_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_INTR  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] saved_pc_q, saved_pc_d;
  logic              int_pend_q, int_pend_d;
  logic [ADDR_W-1:0] load_addr;

  always_comb begin
    unique case (bus.PC_MUX_SEL)
      2'd0:    load_addr = bus.FROM_IMMED;
      2'd1:    load_addr = bus.FROM_STACK;
      2'd2:    load_addr = INT_VECTOR;
      default: load_addr = RESET_ADDR;
    endcase
  end

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    saved_pc_d = saved_pc_q;
    int_pend_d = int_pend_q | bus.INT_REQ;

    unique case (state_q)
      ST_FETCH: begin
        if (!bus.STALL) state_d = ST_EXEC;
      end

      ST_EXEC: begin
        if (!bus.STALL) begin
          pc_d = bus.PC_LD ? load_addr : pc_q + 1'b1;
          if ((int_pend_q | bus.INT_REQ) && bus.INT_EN) begin
            state_d    = ST_INTR;
            // Return address is the already-updated PC, including a same-cycle load.
            saved_pc_d = pc_d;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_INTR: begin
        pc_d       = INT_VECTOR;
        // A request arriving during the acknowledge cycle must stay pending.
        int_pend_d = bus.INT_REQ;
        state_d    = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_ADDR;
      saved_pc_q <= '0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      saved_pc_q <= saved_pc_d;
      int_pend_q <= int_pend_d;
    end
  end

  assign bus.PC_COUNT = pc_q;
  assign bus.EXEC_EN  = (state_q == ST_EXEC);
  assign bus.INT_ACK  = (state_q == ST_INTR);
  assign bus.SAVED_PC = saved_pc_q;
  assign bus.INT_PEND = int_pend_q;

endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
Program-counter and fetch sequencer that sits directly upstream of the 1024x18 program ROM.
- Drives PC_COUNT onto the ROM address input.
- Sequences FETCH/EXEC/INTR phases around the ROM's one-cycle registered read.
- Tells the decoder when the instruction register output is valid.
- Handles next-address selection (increment, branch/call, return), interrupt latching and vectoring, and stalls.

Parameters:
ADDR_W, 10, PC/ROM address width
RESET_ADDR, 10'h000, PC value on reset
INT_VECTOR, 10'h3FF, interrupt service address

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
STALL  in  1  hold current state and PC (ignored in INTR)
PC_LD  in  1  in EXEC: load PC from mux source instead of incrementing
PC_MUX_SEL  in  2  load source: 0=FROM_IMMED, 1=FROM_STACK, 2=INT_VECTOR, 3=RESET_ADDR
FROM_IMMED  in  ADDR_W  branch/call target from instruction field
FROM_STACK  in  ADDR_W  return address popped from stack
INT_REQ  in  1  interrupt request; a one-cycle pulse is sufficient
INT_EN  in  1  global interrupt enable (I flag)
PC_COUNT  out  ADDR_W  current PC, wired to the ROM address
EXEC_EN  out  1  high in EXEC: the ROM instruction output is valid and the decoder executes it
INT_ACK  out  1  one-cycle pulse in INTR
SAVED_PC  out  ADDR_W  return address to push during INTR
INT_PEND  out  1  latched pending interrupt

Behaviour:
- One clock, CLK. RST is asynchronous and active-high, and overrides everything.
- On reset: PC_COUNT=RESET_ADDR, state=FETCH, EXEC_EN=0, INT_ACK=0, SAVED_PC=0, INT_PEND=0.
- States: FETCH, EXEC, INTR. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- FETCH:
  - PC_COUNT is stable at the ROM address; the ROM captures the instruction at the end of this cycle.
  - Next state is EXEC, or stay in FETCH if STALL=1.
- EXEC:
  - EXEC_EN=1.
  - If STALL=1: stay in EXEC; no PC change.
  - Otherwise, at the clock edge, PC is updated:
    - PC_LD=1: PC <= selected source.
    - PC_LD=0: PC <= PC+1, modulo 2^ADDR_W (0x3FF wraps to 0x000).
  - Next state is INTR if INT_PEND|INT_REQ is set and INT_EN=1; otherwise FETCH.
- INTR:
  - Lasts exactly one cycle; STALL is ignored.
  - INT_ACK=1 and SAVED_PC holds the PC already updated in EXEC, which is the return address.
  - At the edge: PC <= INT_VECTOR and INT_PEND clears. Next state is FETCH.
- Interrupt pending latch:
  - INT_PEND is set on any cycle with INT_REQ=1 and cleared on the INTR edge.
  - If INT_REQ=1 during INTR itself, the pending latch stays set: set wins over clear, so a new request is not lost.
  - With INT_EN=0, the request stays pending until INT_EN rises and an EXEC completes.
- Latency: one instruction takes 2 cycles (FETCH+EXEC) with no stall. An interrupt adds 1 cycle.
- PC_LD and an interrupt in the same EXEC: the load is applied first, and SAVED_PC is the loaded target.
- Reset mid-EXEC or mid-INTR: immediately returns to FETCH at RESET_ADDR. No INT_ACK is produced and the pending latch is lost.
- SAVED_PC holds its last value outside INTR.

Test Plan:
- Reset release, no loads, STALL=0 for 8 cycles -> PC_COUNT 0,0,1,1,2,2,3,3; EXEC_EN toggles 0,1,0,1...
- PC at 0x3FF, EXEC with PC_LD=0 -> next PC_COUNT=0x000 (wrap).
- EXEC with PC_LD=1, SEL=0, FROM_IMMED=0x155 -> FETCH at 0x155. Then SEL=1, FROM_STACK=0x020 -> FETCH at 0x020.
- Single-cycle INT_REQ pulse during FETCH at PC=0x010, INT_EN=1:
  - EXEC at 0x010, then INTR with INT_ACK=1 and SAVED_PC=0x011.
  - Then FETCH at 0x3FF; INT_PEND=0.
- INT_REQ pulse with INT_EN=0 -> INT_PEND stays 1 and no INTR. Raise INT_EN -> INTR after the next EXEC.
- STALL=1 for 3 cycles in EXEC at PC=0x005 -> EXEC_EN held high and PC stays 0x005. Assert RST asynchronously mid-stall -> PC_COUNT=0 and state=FETCH before the next edge.
